decode_hazard_ctrl: RTL and testbench
=====================================

Name: decode_hazard_ctrl

Overview:
- Sequencing controller for the first decode stage: generates that stage's STALL and FLUSH, and marks which decoded instructions may issue.
- Tracks in-flight load destinations in a 32-entry scoreboard and holds decode on read-after-write hazards.
- Turns branch/jump redirects into a multi-cycle flush plus a registered PC redirect to fetch.
- Also handles external halt and memory-wait requests.
- Sits between the first decode stage, the fetch unit and the writeback stage.

Parameters:
- FLUSH_CYCLES, 2, cycles FLUSH stays high per redirect (legal range 1..15).
- LOAD_OPCODE, 7'b0000011, opcode class that marks rd busy until writeback.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- DEC_OPCODE  in  7  opcode from decode stage 1 (7'b0 = bubble)
- DEC_RD  in  5  destination register
- DEC_RS1  in  5  source register 1
- DEC_RS2  in  5  source register 2
- WB_VALID  in  1  writeback of a load result this cycle
- WB_RD  in  5  register written back
- REDIRECT_VALID  in  1  branch/jump resolved taken, pipeline must be squashed
- REDIRECT_PC  in  32  target PC
- HALT_REQ  in  1  level request to freeze decode (debug/ecall)
- MEM_WAIT  in  1  downstream memory not ready
- STALL  out  1  hold decode stage 1 registers
- FLUSH  out  1  clear decode stage 1 registers
- ISSUE_VALID  out  1  current decoded instruction is accepted downstream
- FETCH_REDIRECT  out  1  one-cycle pulse to fetch
- FETCH_REDIRECT_PC  out  32  PC accompanying FETCH_REDIRECT
- HALTED  out  1  controller in HALT state
- STALL_CNT  out  16  saturating count of cycles with STALL=1

Behaviour:
- Reset (RST_N low, async): state=RUN, scoreboard=0, flush counter=0, FETCH_REDIRECT=0, FETCH_REDIRECT_PC=0, STALL_CNT=0. Outputs while in reset: STALL=0, FLUSH=0, ISSUE_VALID=0, HALTED=0. Reset mid-flush or mid-halt abandons the operation immediately.
- States:
  - RUN:
    - REDIRECT_VALID and FLUSH_CYCLES>1 → FLUSH with cnt=FLUSH_CYCLES-1.
    - REDIRECT_VALID and FLUSH_CYCLES=1 → stay RUN.
    - else HALT_REQ → HALT.
  - FLUSH:
    - cnt decrements each cycle. When cnt reaches 1, next state is HALT if HALT_REQ, else RUN.
    - REDIRECT_VALID reloads cnt=FLUSH_CYCLES-1 and re-latches the PC.
  - HALT:
    - REDIRECT_VALID → FLUSH (or RUN if FLUSH_CYCLES=1).
    - else !HALT_REQ → RUN.
- FLUSH = REDIRECT_VALID | (state==FLUSH). It is combinational, so the redirect cycle itself flushes, giving exactly FLUSH_CYCLES high cycles.
- FETCH_REDIRECT / FETCH_REDIRECT_PC: registered. Pulse appears 1 cycle after REDIRECT_VALID, carrying the REDIRECT_PC captured that cycle.
- Operand use by opcode:
  - rs1 used unless opcode ∈ {0110111, 0010111, 1101111} or bubble.
  - rs2 used only for 0110011, 0100011, 1100011.
  - rd written unless opcode ∈ {0100011, 1100011}, bubble, or rd=0.
- Hazard = used rs (≠x0) has its scoreboard bit set and is not being cleared this cycle. Same-cycle WB_VALID with WB_RD equal to that rs acts as a bypass and does not stall.
- STALL (combinational) = !FLUSH & (state==HALT | MEM_WAIT | hazard).
- Priority: reset > redirect > halt > MEM_WAIT > hazard.
- ISSUE_VALID = state==RUN & !FLUSH & !STALL & opcode≠0.
- Scoreboard update:
  - Set bit rd when ISSUE_VALID & opcode==LOAD_OPCODE & rd≠0.
  - Clear bit WB_RD on WB_VALID.
  - Set and clear of the same register in one cycle: set wins.
  - x0 is never set.
  - FLUSH does not clear the scoreboard; older loads still write back.
- STALL_CNT increments every cycle STALL=1 and saturates at 16'hFFFF.
- HALTED = state==HALT.

Test Plan:
- Load x5 issued (opcode 0000011, rd=5); next instruction add with rs1=5 → STALL=1, ISSUE_VALID=0 until WB_VALID/WB_RD=5. On that WB cycle STALL=0 (bypass); scoreboard bit 5 = 0 afterwards.
- REDIRECT_VALID for one cycle with REDIRECT_PC=0x0000_0100, FLUSH_CYCLES=2 → FLUSH high for exactly 2 cycles. FETCH_REDIRECT pulses 1 cycle after with PC 0x100. STALL=0 throughout.
- Second redirect (PC 0x200) during FLUSH state → counter reloads, FLUSH extends 2 cycles from the new redirect; FETCH_REDIRECT_PC=0x200.
- HALT_REQ held 5 cycles during RUN → HALTED=1 and STALL=1 from the next cycle, for 5 cycles. Returns to RUN the cycle after HALT_REQ drops. STALL_CNT increases by the number of STALL cycles.
- Load rd=0, then rs1=0 consumer; and LUI with rs1 field=5 while x5 is busy → no stall in either case.
- RST_N asserted mid-flush with scoreboard bit 7 set → all outputs and state reset asynchronously, before the next clock edge. After release, an instruction with rs1=7 issues without stalling.

Source files
------------

// File: rtl/decode_hazard_ctrl_if.sv
// Signal bundle between the first decode stage, fetch, writeback and the
// decode hazard controller. The controller uses the slave modport; the
// pipeline side (or a bench) uses the master modport.
//
// Handshake: the controller has no valid/ready pair. issue_valid is a
// single-cycle qualifier. When it is high, the instruction presented on
// dec_* during that cycle is accepted downstream at the next rising edge.
// While stall is high the decode registers must hold. While flush is high
// they must be cleared. fetch_redirect is a one-cycle pulse. The fetch
// unit must take fetch_redirect_pc in the cycle that fetch_redirect is high.
// state and sb are observation-only copies of the FSM state and the scoreboard.
interface decode_hazard_ctrl_if;
  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        mem_wait;
  logic        stall;
  logic        flush;
  logic        issue_valid;
  logic        fetch_redirect;
  logic [31:0] fetch_redirect_pc;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [1:0]  state;
  logic [31:0] sb;

  modport master (
    output dec_opcode, dec_rd, dec_rs1, dec_rs2, wb_valid, wb_rd,
           redirect_valid, redirect_pc, halt_req, mem_wait,
    input  stall, flush, issue_valid, fetch_redirect, fetch_redirect_pc,
           halted, stall_cnt, state, sb
  );

  modport slave (
    input  dec_opcode, dec_rd, dec_rs1, dec_rs2, wb_valid, wb_rd,
           redirect_valid, redirect_pc, halt_req, mem_wait,
    output stall, flush, issue_valid, fetch_redirect, fetch_redirect_pc,
           halted, stall_cnt, state, sb
  );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencing controller. It produces stall and flush for
// decode stage 1. It tracks in-flight load destinations in a 32-bit
// scoreboard. It turns redirects into a multi-cycle flush and a registered
// fetch redirect. It also freezes decode on halt requests and on memory-wait.
module decode_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [6:0]  LOAD_OPCODE  = 7'b0000011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // The redirect cycle itself flushes combinationally. The FLUSH state
  // therefore covers only the remaining FLUSH_CYCLES-1 cycles.
  localparam bit         MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic [1:0]  state_q, state_nxt;
  logic [3:0]  cnt_q, cnt_nxt;
  logic [31:0] sb_q, sb_nxt;
  logic        fr_q;
  logic [31:0] fr_pc_q;
  logic [15:0] stall_cnt_q;

  logic        bubble, rs1_used, rs2_used, rd_written;
  logic        rs1_blk, rs2_blk, hazard;
  logic        flush, stall, issue, sb_set;

  // Operand usage decoded from the opcode class
  always_comb begin
    bubble     = (bus.dec_opcode == 7'd0);
    rs1_used   = !bubble && (bus.dec_opcode != OP_LUI) &&
                 (bus.dec_opcode != OP_AUIPC) && (bus.dec_opcode != OP_JAL);
    rs2_used   = (bus.dec_opcode == OP_REG) || (bus.dec_opcode == OP_STORE) ||
                 (bus.dec_opcode == OP_BR);
    rd_written = !bubble && (bus.dec_opcode != OP_STORE) &&
                 (bus.dec_opcode != OP_BR) && (bus.dec_rd != 5'd0);
  end

  // RAW hazard: a busy source register stalls decode. A same-cycle
  // writeback of that register is bypassed and does not stall.
  always_comb begin
    rs1_blk = (bus.dec_rs1 != 5'd0) && sb_q[bus.dec_rs1] &&
              !(bus.wb_valid && (bus.wb_rd == bus.dec_rs1));
    rs2_blk = (bus.dec_rs2 != 5'd0) && sb_q[bus.dec_rs2] &&
              !(bus.wb_valid && (bus.wb_rd == bus.dec_rs2));
    hazard  = (rs1_used && rs1_blk) || (rs2_used && rs2_blk);
  end

  // Stage controls, all forced low while reset is asserted. A redirect
  // overrides halt, memory-wait and hazards.
  always_comb begin
    flush  = rst_n && (bus.redirect_valid || (state_q == ST_FLUSH));
    stall  = rst_n && !flush &&
             ((state_q == ST_HALT) || bus.mem_wait || hazard);
    issue  = rst_n && (state_q == ST_RUN) && !flush && !stall && !bubble;
    sb_set = issue && (bus.dec_opcode == LOAD_OPCODE) && rd_written;
  end

  // FSM next state. A redirect always restarts the flush window,
  // whichever state the FSM is in.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (bus.redirect_valid) begin
      state_nxt = MULTI ? ST_FLUSH : ST_RUN;
      cnt_nxt   = MULTI ? RELOAD : 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.halt_req) state_nxt = ST_HALT;
        end
        ST_FLUSH: begin
          if (cnt_q <= 4'd1) begin
            state_nxt = bus.halt_req ? ST_HALT : ST_RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt_q - 4'd1;
          end
        end
        ST_HALT: begin
          if (!bus.halt_req) state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Scoreboard next value. The set is applied after the clear, so set
  // wins on the same register. x0 is never marked busy.
  always_comb begin
    sb_nxt = sb_q;
    if (bus.wb_valid) sb_nxt[bus.wb_rd] = 1'b0;
    if (sb_set)       sb_nxt[bus.dec_rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  // State, scoreboard, fetch redirect register and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= 4'd0;
      sb_q        <= 32'd0;
      fr_q        <= 1'b0;
      fr_pc_q     <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      sb_q    <= sb_nxt;
      fr_q    <= bus.redirect_valid;
      if (bus.redirect_valid) fr_pc_q <= bus.redirect_pc;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall             = stall;
  assign bus.flush             = flush;
  assign bus.issue_valid       = issue;
  assign bus.fetch_redirect    = fr_q;
  assign bus.fetch_redirect_pc = fr_pc_q;
  assign bus.halted            = rst_n && (state_q == ST_HALT);
  assign bus.stall_cnt         = stall_cnt_q;
  assign bus.state             = state_q;
  assign bus.sb                = sb_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl. It uses a directed vector table, hand
// sequences for redirect, halt and reset, and random cycles. All of them are
// checked against a cycle-level model of the controller's rules.
module tb_decode_hazard_ctrl;

  localparam int FC = 2;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        rdv;
    logic [31:0] pc;
    logic        halt, mw;
  } in_t;

  typedef struct {
    in_t  i;
    logic e_stall, e_flush, e_issue, e_halted;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_hazard_ctrl_if bus();
  decode_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;

  // model state: remaining FLUSH-state cycles, halt flag, busy registers
  bit          m_halted;
  int          m_rem;
  bit [31:0]   m_busy;
  int          m_cnt;
  bit          m_fr;
  bit [31:0]   m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                             input logic wbv, input logic [4:0] wbrd, input logic rdv,
                             input logic [31:0] pc, input logic halt, mw);
    in_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.wbv = wbv; r.wbrd = wbrd;
    r.rdv = rdv; r.pc = pc; r.halt = halt; r.mw = mw;
    return r;
  endfunction

  function automatic bit uses_rs1(input logic [6:0] op);
    return (op != 7'd0) && !(op inside {OP_LUI, 7'b0010111, OP_JAL});
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {OP_ADD, OP_SW, OP_BEQ};
  endfunction

  function automatic bit blocked(input in_t i, input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(i.wbv && (i.wbrd == r));
  endfunction

  task automatic model_reset();
    m_halted = 0; m_rem = 0; m_busy = 0; m_cnt = 0; m_fr = 0; m_pc = 0;
  endtask

  task automatic drive(input in_t i);
    bus.dec_opcode = i.op; bus.dec_rd = i.rd; bus.dec_rs1 = i.rs1; bus.dec_rs2 = i.rs2;
    bus.wb_valid = i.wbv; bus.wb_rd = i.wbrd; bus.redirect_valid = i.rdv;
    bus.redirect_pc = i.pc; bus.halt_req = i.halt; bus.mem_wait = i.mw;
  endtask

  // One cycle: drive at the falling edge, compare against the model, then advance the model
  task automatic step(input in_t i);
    bit e_flush, e_stall, e_issue, hz;
    @(negedge clk);
    drive(i);
    #1;
    hz      = (uses_rs1(i.op) && blocked(i, i.rs1)) || (uses_rs2(i.op) && blocked(i, i.rs2));
    e_flush = i.rdv || (m_rem > 0);
    e_stall = !e_flush && (m_halted || i.mw || hz);
    e_issue = !m_halted && (m_rem == 0) && !e_flush && !e_stall && (i.op != 7'd0);
    check("stall",    32'(bus.stall),          32'(e_stall));
    check("flush",    32'(bus.flush),          32'(e_flush));
    check("issue",    32'(bus.issue_valid),    32'(e_issue));
    check("halted",   32'(bus.halted),         32'(m_halted));
    check("fetch_rd", 32'(bus.fetch_redirect), 32'(m_fr));
    check("fetch_pc", bus.fetch_redirect_pc,   m_pc);
    check("stall_cnt", 32'(bus.stall_cnt),     32'(m_cnt));
    check("scoreboard", bus.sb,                m_busy);
    if (e_stall && m_cnt < 65535) m_cnt++;
    if (i.wbv) m_busy[i.wbrd] = 1'b0;
    if (e_issue && i.op == OP_LD && i.rd != 5'd0) m_busy[i.rd] = 1'b1;
    m_fr = i.rdv;
    if (i.rdv) m_pc = i.pc;
    if (i.rdv) begin
      m_halted = 0;
      m_rem    = FC - 1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_halted = i.halt;
    end else begin
      m_halted = i.halt;
    end
  endtask

  vec_t tbl[16];
  in_t  nop;

  initial begin
    int halted_cycles;
    int base_cnt;
    bit halt_lvl;
    nop = mk(7'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0);

    tbl[0]  = '{mk(OP_LD,  5, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0};
    tbl[1]  = '{mk(OP_ADD, 6, 5, 2, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0};
    tbl[2]  = '{mk(OP_ADD, 6, 5, 2, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0};
    tbl[3]  = '{mk(OP_ADD, 6, 5, 2, 1, 5, 0, 0, 0, 0), 0, 0, 1, 0};
    tbl[4]  = '{mk(OP_ADD, 6, 5, 5, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0};
    tbl[5]  = '{mk(OP_LD,  0, 3, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0};
    tbl[6]  = '{mk(OP_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0};
    tbl[7]  = '{mk(OP_LD,  5, 2, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0};
    tbl[8]  = '{mk(OP_LUI, 9, 5, 5, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0};
    tbl[9]  = '{mk(OP_SW,  0, 1, 5, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0};
    tbl[10] = '{mk(OP_BEQ, 0, 5, 1, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0};
    tbl[11] = '{mk(7'd0,   0, 5, 0, 1, 5, 0, 0, 0, 0), 0, 0, 0, 0};
    tbl[12] = '{mk(OP_ADD, 3, 1, 2, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0};
    tbl[13] = '{mk(OP_ADD, 3, 1, 2, 0, 0, 1, 32'h100, 0, 1), 0, 1, 0, 0};
    tbl[14] = '{mk(OP_ADD, 3, 1, 2, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0};
    tbl[15] = '{mk(OP_ADD, 3, 1, 2, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0};

    // reset with every input pushing outputs high
    rst_n = 1'b0;
    model_reset();
    drive(mk(OP_ADD, 1, 2, 3, 1, 4, 1, 32'hDEAD, 1, 1));
    #1;
    check("rst_stall",  32'(bus.stall),       0);
    check("rst_flush",  32'(bus.flush),       0);
    check("rst_issue",  32'(bus.issue_valid), 0);
    check("rst_halted", 32'(bus.halted),      0);
    check("rst_fr",     32'(bus.fetch_redirect), 0);
    check("rst_cnt",    32'(bus.stall_cnt),   0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(nop);
    rst_n = 1'b1;

    // directed vector table
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].i);
      check($sformatf("tbl%0d_stall", k),  32'(bus.stall),       32'(tbl[k].e_stall));
      check($sformatf("tbl%0d_flush", k),  32'(bus.flush),       32'(tbl[k].e_flush));
      check($sformatf("tbl%0d_issue", k),  32'(bus.issue_valid), 32'(tbl[k].e_issue));
      check($sformatf("tbl%0d_halted", k), 32'(bus.halted),      32'(tbl[k].e_halted));
    end
    check("tbl_stall_cnt", 32'(bus.stall_cnt), 5);
    check("tbl_sb5_clear", 32'(bus.sb[5]), 0);

    // second redirect during the flush window
    step(mk(OP_ADD, 3, 1, 2, 0, 0, 1, 32'h100, 0, 0));
    check("rr_flush0", 32'(bus.flush), 1);
    step(mk(OP_ADD, 3, 1, 2, 0, 0, 1, 32'h200, 0, 0));
    check("rr_flush1", 32'(bus.flush), 1);
    check("rr_pc1",    bus.fetch_redirect_pc, 32'h100);
    step(mk(OP_ADD, 3, 1, 2, 0, 0, 0, 0, 0, 0));
    check("rr_flush2", 32'(bus.flush), 1);
    check("rr_fr2",    32'(bus.fetch_redirect), 1);
    check("rr_pc2",    bus.fetch_redirect_pc, 32'h200);
    step(mk(OP_ADD, 3, 1, 2, 0, 0, 0, 0, 0, 0));
    check("rr_flush3", 32'(bus.flush), 0);
    check("rr_fr3",    32'(bus.fetch_redirect), 0);
    check("rr_stall3", 32'(bus.stall), 0);

    // halt request held for 5 cycles
    base_cnt = m_cnt;
    halted_cycles = 0;
    for (int k = 0; k < 7; k++) begin
      step(mk(OP_ADD, 3, 1, 2, 0, 0, 0, 0, (k < 5) ? 1'b1 : 1'b0, 0));
      if (bus.halted && bus.stall) halted_cycles++;
    end
    check("halt_cycles", halted_cycles, 5);
    check("halt_exit",   32'(bus.halted), 0);
    check("halt_issue",  32'(bus.issue_valid), 1);
    check("halt_cnt",    32'(bus.stall_cnt), 32'(base_cnt + 5));

    // asynchronous reset in the middle of a flush while x7 is busy
    step(mk(OP_LD, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    step(mk(7'd0, 0, 0, 0, 0, 0, 1, 32'h300, 0, 0));
    @(negedge clk);
    drive(mk(OP_ADD, 3, 7, 7, 0, 0, 1, 32'h400, 1, 1));
    #1;
    check("mid_flush", 32'(bus.flush), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_flush",  32'(bus.flush),          0);
    check("arst_stall",  32'(bus.stall),          0);
    check("arst_issue",  32'(bus.issue_valid),    0);
    check("arst_fr",     32'(bus.fetch_redirect), 0);
    check("arst_pc",     bus.fetch_redirect_pc,   0);
    check("arst_cnt",    32'(bus.stall_cnt),      0);
    check("arst_sb",     bus.sb,                  0);
    model_reset();
    @(negedge clk);
    drive(nop);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(OP_ADD, 3, 7, 0, 0, 0, 0, 0, 0, 0));
    check("post_rst_issue", 32'(bus.issue_valid), 1);
    check("post_rst_stall", 32'(bus.stall), 0);

    // random cycles against the model
    halt_lvl = 0;
    for (int k = 0; k < 400; k++) begin
      in_t r;
      logic [6:0] ops[8];
      ops = '{7'd0, OP_LD, OP_LD, OP_ADD, OP_SW, OP_BEQ, OP_LUI, OP_IMM};
      if ($urandom_range(0, 7) == 0) halt_lvl = ~halt_lvl;
      r = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
             ($urandom_range(0, 9) == 0), $urandom, halt_lvl, ($urandom_range(0, 5) == 0));
      step(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
